panxi_spsram_arb: RTL and testbench
===================================

Name: panxi_spsram_arb

Overview:
- Two-port round-robin arbiter and sequencer in front of one panxi_spsram_1024x32 single-port SRAM.
- Port I is the instruction fetch port and is read-only. Port D is the load/store port and supports read and write with byte strobes.
- Converts valid/ready request and response handshakes into SRAM CEN/GWEN/AWEN strobes, captures the 1-cycle-latency read data, and holds each port's response until that port accepts it.

Parameters:
- ADDR_WIDTH, 10, SRAM word-address width.
- DATA_WIDTH, 32, SRAM data width; must be a multiple of 8.
- STRB_WIDTH, DATA_WIDTH/8, number of byte strobes on port D.

Ports:
- ACLK  in  1  clock; all logic is on the rising edge.
- ARST  in  1  synchronous, active-high reset.
- I_REQ_VALID  in  1  port I read request.
- I_REQ_READY  out  1  port I request accepted this cycle.
- I_REQ_ADDR  in  ADDR_WIDTH  port I word address.
- I_RSP_VALID  out  1  port I read data valid.
- I_RSP_READY  in  1  port I response consumed.
- I_RSP_DATA  out  DATA_WIDTH  port I read data.
- D_REQ_VALID  in  1  port D request.
- D_REQ_READY  out  1  port D request accepted this cycle.
- D_REQ_WRITE  in  1  1 = write, 0 = read.
- D_REQ_ADDR  in  ADDR_WIDTH  port D word address.
- D_REQ_WDATA  in  DATA_WIDTH  port D write data.
- D_REQ_STRB  in  STRB_WIDTH  byte enables, active high.
- D_RSP_VALID  out  1  port D response (read data or write ack).
- D_RSP_READY  in  1  port D response consumed.
- D_RSP_DATA  out  DATA_WIDTH  read data; 0 for a write ack.
- MEM_CEN  out  1  SRAM chip enable, active low.
- MEM_AADDR  out  ADDR_WIDTH  SRAM address.
- MEM_ADATA_XI  out  DATA_WIDTH  SRAM write data.
- MEM_GWEN  out  1  SRAM global write enable, active low (0 = write).
- MEM_AWEN  out  DATA_WIDTH  SRAM per-bit write enable, active low.
- MEM_ADATA_XO  in  DATA_WIDTH  SRAM read data, valid the cycle after a read access.

Behaviour:
- Outstanding limit: each port has at most one outstanding transaction, tracked by flag OUT_p.
  - OUT_p sets when the request is accepted.
  - OUT_p clears on the response handshake, i.e. RSP_VALID & RSP_READY.
- Eligibility: port p is eligible when REQ_VALID_p & !OUT_p.
- Arbitration: combinational round-robin among eligible ports, using register LAST (last granted port).
  - If both ports are eligible, the port other than LAST wins.
  - If one port is eligible, it wins.
  - REQ_READY_p = 1 only for the winner. LAST updates to the winner on acceptance.
  - There is no combinational path from RSP_READY to REQ_READY.
- SRAM access happens in the same cycle as acceptance:
  - MEM_CEN=0, MEM_AADDR=winner address.
  - Read: MEM_GWEN=1, MEM_AWEN all 1.
  - Port D write: MEM_GWEN=0, MEM_ADATA_XI=D_REQ_WDATA, MEM_AWEN[i] = ~D_REQ_STRB[i/8].
  - A write with all-zero strobes still performs an access (AWEN all 1) and is acked.
- Idle cycles drive MEM_CEN=1, MEM_GWEN=1, MEM_AWEN all 1, MEM_AADDR=0, MEM_ADATA_XI=0.
- Response timing, for an access in cycle N:
  - RSP_VALID_p rises in cycle N+1.
  - In cycle N+1, RSP_DATA_p is driven directly from MEM_ADATA_XO (0 for a write).
  - At the end of N+1 that value is latched into HOLD_p. From N+2 on, RSP_DATA_p = HOLD_p, stable until the handshake.
- RSP_VALID_p stays high until RSP_READY_p is sampled high, then drops the next cycle. OUT_p clears on the same edge.
- Throughput:
  - A single port completes at most one transaction per 2 cycles (accept N, respond N+1, earliest next accept N+2 if the response is taken in N+1).
  - With both ports alternating, the SRAM is accessed every cycle.
- The SRAM is never accessed while no port is eligible. A stalled response on one port never blocks the other port.
- Reset (ARST=1 at a rising edge):
  - OUT_I=OUT_D=0, RSP_VALID=0, HOLD=0, LAST=D (so port I wins the first tie).
  - REQ_READY outputs are 0 while ARST=1.
  - A read in flight is discarded; its data is never presented.
- The request address and data must be stable only in the acceptance cycle.

Test Plan:
- Single read: preload addr 0x005=0xDEADBEEF; I requests 0x005 -> I_REQ_READY=1 in cycle N, MEM_CEN=0, MEM_GWEN=1 in N; I_RSP_VALID=1 with data 0xDEADBEEF in N+1.
- Byte write then read on D:
  - Write 0x3FF data 0x11223344, strobe 4'b0101 over old 0xAAAAAAAA -> MEM_AWEN=0xFF00FF00, MEM_GWEN=0, ack with D_RSP_DATA=0.
  - Read 0x3FF -> 0xAA22AA44.
- Contention: I and D both valid every cycle with RSP_READY=1 -> grants alternate I, D, I, D starting with I after reset; MEM_CEN=0 every cycle.
- Backpressure: I_RSP_READY=0 for 5 cycles after a read of 0x010=0x12345678 -> I_RSP_DATA holds 0x12345678 through those cycles while SRAM data changes from D reads; D continues to be granted every other cycle; I_REQ_READY=0 until I's handshake completes.
- Reset mid-operation: assert ARST in the cycle after an I read is accepted -> I_RSP_VALID=0 and OUT cleared after the edge; first post-reset tie goes to I.
- Zero-strobe write: D write strobe 0 to 0x020 -> access issued with MEM_AWEN=all 1, ack returned, subsequent read of 0x020 returns the old value unchanged.

Source files
------------

// File: rtl/panxi_spsram_arb.sv
// ---------------------------------------------------------------------------
// panxi_spsram_arb
//   Two-port round-robin arbiter/sequencer in front of one single-port SRAM
//   (panxi_spsram_1024x32). Port I is a read-only fetch port, port D is a
//   load/store port with byte strobes. Each port may have one transaction
//   outstanding; its response is held until the port accepts it.
//
// Ports
//   ACLK, ARST                       clock, synchronous active-high reset
//   I_REQ_VALID/READY/ADDR           port I read request
//   I_RSP_VALID/READY/DATA           port I read response
//   D_REQ_VALID/READY/WRITE/ADDR     port D request
//   D_REQ_WDATA/STRB                 port D write data and byte enables
//   D_RSP_VALID/READY/DATA           port D response (read data / write ack)
//   MEM_CEN/AADDR/ADATA_XI/GWEN/AWEN SRAM strobes (active low enables)
//   MEM_ADATA_XO                     SRAM read data, one cycle after access
// ---------------------------------------------------------------------------
module panxi_spsram_arb #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARST,

  input  logic                  I_REQ_VALID,
  output logic                  I_REQ_READY,
  input  logic [ADDR_WIDTH-1:0] I_REQ_ADDR,
  output logic                  I_RSP_VALID,
  input  logic                  I_RSP_READY,
  output logic [DATA_WIDTH-1:0] I_RSP_DATA,

  input  logic                  D_REQ_VALID,
  output logic                  D_REQ_READY,
  input  logic                  D_REQ_WRITE,
  input  logic [ADDR_WIDTH-1:0] D_REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] D_REQ_WDATA,
  input  logic [STRB_WIDTH-1:0] D_REQ_STRB,
  output logic                  D_RSP_VALID,
  input  logic                  D_RSP_READY,
  output logic [DATA_WIDTH-1:0] D_RSP_DATA,

  output logic                  MEM_CEN,
  output logic [ADDR_WIDTH-1:0] MEM_AADDR,
  output logic [DATA_WIDTH-1:0] MEM_ADATA_XI,
  output logic                  MEM_GWEN,
  output logic [DATA_WIDTH-1:0] MEM_AWEN,
  input  logic [DATA_WIDTH-1:0] MEM_ADATA_XO
);

  localparam logic P_I = 1'b0;
  localparam logic P_D = 1'b1;

  // Expand byte strobes into an active-low per-bit write enable.
  function automatic logic [DATA_WIDTH-1:0] f_strb_to_awen(
    input logic [STRB_WIDTH-1:0] strb
  );
    logic [DATA_WIDTH-1:0] awen;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      awen[i] = ~strb[i/8];
    end
    return awen;
  endfunction

  // Outstanding flags. A port's response becomes visible on the same edge
  // that marks it outstanding and retires on the same edge that clears it,
  // so the outstanding flag doubles as the response-valid register.
  logic                  r_out_i;
  logic                  r_out_d;
  logic                  r_last;       // last granted port
  logic                  r_fresh_i;    // access happened last cycle: data on XO
  logic                  r_fresh_d;
  logic                  r_wack_d;     // last D access was a write
  logic [DATA_WIDTH-1:0] r_hold_i;
  logic [DATA_WIDTH-1:0] r_hold_d;

  logic                  w_elig_i;
  logic                  w_elig_d;
  logic                  w_gnt_i;
  logic                  w_gnt_d;
  logic [DATA_WIDTH-1:0] w_i_rsp_data;
  logic [DATA_WIDTH-1:0] w_d_rsp_data;

  // ---- stage 0: arbitration and SRAM access (acceptance cycle) ----
  assign w_elig_i = I_REQ_VALID & ~r_out_i;
  assign w_elig_d = D_REQ_VALID & ~r_out_d;

  // On a tie the port that did not win last time is served.
  assign w_gnt_i = ~ARST & w_elig_i & (~w_elig_d | (r_last == P_D));
  assign w_gnt_d = ~ARST & w_elig_d & (~w_elig_i | (r_last == P_I));

  assign I_REQ_READY = w_gnt_i;
  assign D_REQ_READY = w_gnt_d;

  always_comb begin
    MEM_CEN      = 1'b1;
    MEM_AADDR    = '0;
    MEM_ADATA_XI = '0;
    MEM_GWEN     = 1'b1;
    MEM_AWEN     = '1;
    if (w_gnt_i) begin
      MEM_CEN   = 1'b0;
      MEM_AADDR = I_REQ_ADDR;
    end else if (w_gnt_d) begin
      MEM_CEN   = 1'b0;
      MEM_AADDR = D_REQ_ADDR;
      if (D_REQ_WRITE) begin
        MEM_GWEN     = 1'b0;
        MEM_ADATA_XI = D_REQ_WDATA;
        MEM_AWEN     = f_strb_to_awen(D_REQ_STRB);
      end
    end
  end

  // ---- stage 1: response presentation ----
  // First response cycle forwards SRAM output; later cycles replay the hold.
  assign w_i_rsp_data = r_fresh_i ? MEM_ADATA_XO : r_hold_i;
  assign w_d_rsp_data = r_fresh_d ? (r_wack_d ? '0 : MEM_ADATA_XO) : r_hold_d;

  assign I_RSP_VALID = r_out_i;
  assign D_RSP_VALID = r_out_d;
  assign I_RSP_DATA  = w_i_rsp_data;
  assign D_RSP_DATA  = w_d_rsp_data;

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      r_out_i   <= 1'b0;
      r_out_d   <= 1'b0;
      r_last    <= P_D;
      r_fresh_i <= 1'b0;
      r_fresh_d <= 1'b0;
      r_wack_d  <= 1'b0;
      r_hold_i  <= '0;
      r_hold_d  <= '0;
    end else begin
      // A grant needs the port idle, so set and clear never coincide.
      r_out_i   <= w_gnt_i | (r_out_i & ~I_RSP_READY);
      r_out_d   <= w_gnt_d | (r_out_d & ~D_RSP_READY);
      r_fresh_i <= w_gnt_i;
      r_fresh_d <= w_gnt_d;
      if (w_gnt_d) begin
        r_wack_d <= D_REQ_WRITE;
      end
      if (r_fresh_i) begin
        r_hold_i <= w_i_rsp_data;
      end
      if (r_fresh_d) begin
        r_hold_d <= w_d_rsp_data;
      end
      if (w_gnt_i) begin
        r_last <= P_I;
      end else if (w_gnt_d) begin
        r_last <= P_D;
      end
    end
  end

endmodule

// File: tb/tb_panxi_spsram_arb.sv
// ---------------------------------------------------------------------------
// tb_panxi_spsram_arb
//   Directed bench for panxi_spsram_arb with a behavioural SRAM, a
//   transaction-level reference model checked every cycle, and hand-computed
//   literal expectations for the key scenarios.
// ---------------------------------------------------------------------------
module tb_panxi_spsram_arb;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          ACLK = 1'b0;
  logic          ARST;
  logic          I_REQ_VALID, I_REQ_READY;
  logic [AW-1:0] I_REQ_ADDR;
  logic          I_RSP_VALID, I_RSP_READY;
  logic [DW-1:0] I_RSP_DATA;
  logic          D_REQ_VALID, D_REQ_READY, D_REQ_WRITE;
  logic [AW-1:0] D_REQ_ADDR;
  logic [DW-1:0] D_REQ_WDATA;
  logic [SW-1:0] D_REQ_STRB;
  logic          D_RSP_VALID, D_RSP_READY;
  logic [DW-1:0] D_RSP_DATA;
  logic          MEM_CEN, MEM_GWEN;
  logic [AW-1:0] MEM_AADDR;
  logic [DW-1:0] MEM_ADATA_XI, MEM_AWEN, MEM_ADATA_XO;

  panxi_spsram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) dut (
    .ACLK(ACLK), .ARST(ARST),
    .I_REQ_VALID(I_REQ_VALID), .I_REQ_READY(I_REQ_READY), .I_REQ_ADDR(I_REQ_ADDR),
    .I_RSP_VALID(I_RSP_VALID), .I_RSP_READY(I_RSP_READY), .I_RSP_DATA(I_RSP_DATA),
    .D_REQ_VALID(D_REQ_VALID), .D_REQ_READY(D_REQ_READY), .D_REQ_WRITE(D_REQ_WRITE),
    .D_REQ_ADDR(D_REQ_ADDR), .D_REQ_WDATA(D_REQ_WDATA), .D_REQ_STRB(D_REQ_STRB),
    .D_RSP_VALID(D_RSP_VALID), .D_RSP_READY(D_RSP_READY), .D_RSP_DATA(D_RSP_DATA),
    .MEM_CEN(MEM_CEN), .MEM_AADDR(MEM_AADDR), .MEM_ADATA_XI(MEM_ADATA_XI),
    .MEM_GWEN(MEM_GWEN), .MEM_AWEN(MEM_AWEN), .MEM_ADATA_XO(MEM_ADATA_XO)
  );

  always #5 ACLK = ~ACLK;

  function automatic logic [DW-1:0] init_val(input int a);
    case (a)
      'h005:   return 32'hDEADBEEF;
      'h3FF:   return 32'hAAAAAAAA;
      'h010:   return 32'h12345678;
      'h020:   return 32'hCAFEF00D;
      default: return (32'(a) * 32'h00010001) ^ 32'h5A5A0000;
    endcase
  endfunction

  // Behavioural single-port SRAM with one-cycle read latency.
  logic          tb_init;
  logic [DW-1:0] sram [1024];
  always @(posedge ACLK) begin
    if (tb_init) begin
      for (int i = 0; i < 1024; i++) sram[i] <= init_val(i);
    end else if (!MEM_CEN) begin
      if (!MEM_GWEN)
        sram[MEM_AADDR] <= (sram[MEM_AADDR] & MEM_AWEN) | (MEM_ADATA_XI & ~MEM_AWEN);
      else
        MEM_ADATA_XO <= sram[MEM_AADDR];
    end
  end

  int n_checks;
  int n_pass;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model: per-port pending response value, memory image, last winner.
  logic [DW-1:0] m_mem [1024];
  logic          m_out [2];
  logic [DW-1:0] m_rsp [2];
  logic          m_last;   // 0 = I, 1 = D

  task automatic model_cycle();
    logic ei, ed, gi, gd;
    logic [DW-1:0] e_awen, e_xi;
    logic [AW-1:0] e_addr;
    logic e_gwen;
    ei = I_REQ_VALID && !m_out[0];
    ed = D_REQ_VALID && !m_out[1];
    if (ARST) begin gi = 0; gd = 0; end
    else if (ei && ed) begin gi = (m_last == 1'b1); gd = !gi; end
    else begin gi = ei; gd = ed; end
    e_addr = '0; e_gwen = 1; e_awen = '1; e_xi = '0;
    if (gi) e_addr = I_REQ_ADDR;
    if (gd) begin
      e_addr = D_REQ_ADDR;
      if (D_REQ_WRITE) begin
        e_gwen = 0; e_xi = D_REQ_WDATA;
        for (int b = 0; b < SW; b++) e_awen[b*8 +: 8] = D_REQ_STRB[b] ? 8'h00 : 8'hFF;
      end
    end
    chk("m_i_req_ready", 32'(I_REQ_READY), 32'(gi));
    chk("m_d_req_ready", 32'(D_REQ_READY), 32'(gd));
    chk("m_cen", 32'(MEM_CEN), 32'(!(gi || gd)));
    if (gi || gd) begin
      chk("m_aaddr", 32'(MEM_AADDR), 32'(e_addr));
      chk("m_gwen", 32'(MEM_GWEN), 32'(e_gwen));
      chk("m_awen", MEM_AWEN, e_awen);
      if (!e_gwen) chk("m_xi", MEM_ADATA_XI, e_xi);
    end else begin
      chk("m_idle_gwen", 32'(MEM_GWEN), 32'd1);
      chk("m_idle_awen", MEM_AWEN, 32'hFFFFFFFF);
      chk("m_idle_addr", 32'(MEM_AADDR), 32'd0);
      chk("m_idle_xi", MEM_ADATA_XI, 32'd0);
    end
    chk("m_i_rsp_valid", 32'(I_RSP_VALID), 32'(m_out[0]));
    chk("m_d_rsp_valid", 32'(D_RSP_VALID), 32'(m_out[1]));
    if (m_out[0]) chk("m_i_rsp_data", I_RSP_DATA, m_rsp[0]);
    if (m_out[1]) chk("m_d_rsp_data", D_RSP_DATA, m_rsp[1]);
    // advance to next cycle
    if (ARST) begin
      m_out[0] = 0; m_out[1] = 0; m_last = 1'b1;
    end else begin
      if (m_out[0] && I_RSP_READY) m_out[0] = 0;
      if (m_out[1] && D_RSP_READY) m_out[1] = 0;
      if (gi) begin
        m_out[0] = 1; m_rsp[0] = m_mem[I_REQ_ADDR]; m_last = 1'b0;
      end
      if (gd) begin
        m_out[1] = 1; m_last = 1'b1;
        if (D_REQ_WRITE) begin
          m_rsp[1] = '0;
          for (int b = 0; b < SW; b++)
            if (D_REQ_STRB[b]) m_mem[D_REQ_ADDR][b*8 +: 8] = D_REQ_WDATA[b*8 +: 8];
        end else begin
          m_rsp[1] = m_mem[D_REQ_ADDR];
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge ACLK);
    model_cycle();
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    tb_init = 1; ARST = 1;
    I_REQ_VALID = 0; I_REQ_ADDR = '0; I_RSP_READY = 1;
    D_REQ_VALID = 0; D_REQ_WRITE = 0; D_REQ_ADDR = '0; D_REQ_WDATA = '0;
    D_REQ_STRB = '0; D_RSP_READY = 1;
    for (int i = 0; i < 1024; i++) m_mem[i] = init_val(i);
    m_out[0] = 0; m_out[1] = 0; m_rsp[0] = '0; m_rsp[1] = '0; m_last = 1'b1;
    tick(); tick();
    chk("rst_i_rsp_valid", 32'(I_RSP_VALID), 32'd0);
    chk("rst_d_rsp_valid", 32'(D_RSP_VALID), 32'd0);
    chk("rst_cen", 32'(MEM_CEN), 32'd1);
    tb_init = 0; ARST = 0;

    // Single read on I
    I_REQ_VALID = 1; I_REQ_ADDR = 10'h005; #1;
    chk("s1_i_ready", 32'(I_REQ_READY), 32'd1);
    chk("s1_cen", 32'(MEM_CEN), 32'd0);
    chk("s1_gwen", 32'(MEM_GWEN), 32'd1);
    tick();
    I_REQ_VALID = 0; #1;
    chk("s1_rsp_valid", 32'(I_RSP_VALID), 32'd1);
    chk("s1_rsp_data", I_RSP_DATA, 32'hDEADBEEF);
    tick(); #1;
    chk("s1_rsp_dropped", 32'(I_RSP_VALID), 32'd0);

    // Byte write then read on D
    D_REQ_VALID = 1; D_REQ_WRITE = 1; D_REQ_ADDR = 10'h3FF;
    D_REQ_WDATA = 32'h11223344; D_REQ_STRB = 4'b0101; #1;
    chk("s2_d_ready", 32'(D_REQ_READY), 32'd1);
    chk("s2_gwen", 32'(MEM_GWEN), 32'd0);
    chk("s2_awen", MEM_AWEN, 32'hFF00FF00);
    tick();
    D_REQ_VALID = 0; #1;
    chk("s2_ack_valid", 32'(D_RSP_VALID), 32'd1);
    chk("s2_ack_data", D_RSP_DATA, 32'd0);
    tick();
    D_REQ_VALID = 1; D_REQ_WRITE = 0; #1;
    chk("s2_rd_ready", 32'(D_REQ_READY), 32'd1);
    tick();
    D_REQ_VALID = 0; #1;
    chk("s2_rd_data", D_RSP_DATA, 32'hAA22AA44);
    tick();

    // Contention after reset: I, D, I, D ...
    ARST = 1; tick(); ARST = 0;
    I_REQ_VALID = 1; D_REQ_VALID = 1; D_REQ_WRITE = 0;
    for (int k = 0; k < 8; k++) begin
      I_REQ_ADDR = 10'(k); D_REQ_ADDR = 10'(32'h100 + k); #1;
      chk("s3_i_grant", 32'(I_REQ_READY), 32'((k % 2) == 0));
      chk("s3_d_grant", 32'(D_REQ_READY), 32'((k % 2) == 1));
      chk("s3_cen", 32'(MEM_CEN), 32'd0);
      tick();
    end
    I_REQ_VALID = 0; D_REQ_VALID = 0; tick();

    // Backpressure on I while D keeps reading
    I_REQ_VALID = 1; I_REQ_ADDR = 10'h010; I_RSP_READY = 0;
    D_REQ_VALID = 1; D_REQ_ADDR = 10'h200; #1;
    chk("s4_i_ready", 32'(I_REQ_READY), 32'd1);
    tick();
    for (int k = 1; k < 7; k++) begin
      I_RSP_READY = (k == 6); D_REQ_ADDR = 10'(32'h200 + k); #1;
      chk("s4_i_blocked", 32'(I_REQ_READY), 32'd0);
      chk("s4_i_valid", 32'(I_RSP_VALID), 32'd1);
      chk("s4_i_hold", I_RSP_DATA, 32'h12345678);
      chk("s4_d_grant", 32'(D_REQ_READY), 32'((k % 2) == 1));
      tick();
    end
    #1;
    chk("s4_i_regrant", 32'(I_REQ_READY), 32'd1);
    tick();
    I_REQ_VALID = 0; D_REQ_VALID = 0; tick(); tick();

    // Reset in the cycle after an I read is accepted
    I_REQ_VALID = 1; I_REQ_ADDR = 10'h005; #1;
    chk("s5_i_ready", 32'(I_REQ_READY), 32'd1);
    tick();
    I_REQ_VALID = 0; ARST = 1; tick(); ARST = 0; #1;
    chk("s5_rsp_killed", 32'(I_RSP_VALID), 32'd0);
    I_REQ_VALID = 1; D_REQ_VALID = 1; D_REQ_WRITE = 0; D_REQ_ADDR = 10'h001; #1;
    chk("s5_tie_i", 32'(I_REQ_READY), 32'd1);
    chk("s5_tie_d", 32'(D_REQ_READY), 32'd0);
    tick();
    I_REQ_VALID = 0; D_REQ_VALID = 0; tick(); tick();

    // Zero-strobe write still accesses and acks, data unchanged
    D_REQ_VALID = 1; D_REQ_WRITE = 1; D_REQ_ADDR = 10'h020;
    D_REQ_WDATA = 32'hFFFFFFFF; D_REQ_STRB = 4'b0000; #1;
    chk("s6_cen", 32'(MEM_CEN), 32'd0);
    chk("s6_gwen", 32'(MEM_GWEN), 32'd0);
    chk("s6_awen", MEM_AWEN, 32'hFFFFFFFF);
    tick();
    D_REQ_VALID = 0; #1;
    chk("s6_ack_valid", 32'(D_RSP_VALID), 32'd1);
    chk("s6_ack_data", D_RSP_DATA, 32'd0);
    tick();
    D_REQ_VALID = 1; D_REQ_WRITE = 0; tick();
    D_REQ_VALID = 0; #1;
    chk("s6_rd_data", D_RSP_DATA, 32'hCAFEF00D);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
